// File: rtl/irq_controller_if.sv
// Bus and CPU interrupt-handshake signals shared by the interrupt controller and its master.
interface irq_controller_if #(
    parameter int BITS  = 32,
    parameter int N_DEV = 4
);
    logic             we;
    logic             re;
    logic [BITS-1:0]  memAddr;
    logic [BITS-1:0]  dataBusIn;
    logic [BITS-1:0]  dataBusOut;
    logic [N_DEV-1:0] irqIn;
    logic             intAck;
    logic             intReq;

    modport master (
        output we, re, memAddr, dataBusIn, irqIn, intAck,
        input  dataBusOut, intReq
    );

    modport slave (
        input  we, re, memAddr, dataBusIn, irqIn, intAck,
        output dataBusOut, intReq
    );
endinterface

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: edge capture, masking, lowest-index priority
// and a request/acknowledge/end-of-interrupt handshake with the CPU.
module irq_controller #(
    parameter int              BITS       = 32,
    parameter int              N_DEV      = 4,
    parameter logic [BITS-1:0] PEND_ADDR  = 32'hF0000800,
    parameter logic [BITS-1:0] MASK_ADDR  = 32'hF0000804,
    parameter logic [BITS-1:0] CAUSE_ADDR = 32'hF0000808,
    parameter logic [BITS-1:0] EOI_ADDR   = 32'hF000080C
) (
    input logic clk,
    input logic reset,
    irq_controller_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] SERV = 2'd2;

    logic [1:0]       state;
    logic [N_DEV-1:0] pend;
    logic [N_DEV-1:0] mask;
    logic [N_DEV-1:0] irqPrev;
    logic [N_DEV-1:0] rise;
    logic [N_DEV-1:0] eligible;
    logic [N_DEV-1:0] selOneHot;
    logic [N_DEV-1:0] ackClr;
    logic [3:0]       sel;
    logic [3:0]       selId;
    logic [3:0]       causeId;
    logic             causeActive;
    logic             selEligible;
    logic             ackNow;
    logic             wrMask;
    logic             wrEoi;
    logic             rdPend;
    logic             rdMask;
    logic             rdCause;
    logic             unusedData;

    assign unusedData = ^bus.dataBusIn[BITS-1:N_DEV];

    assign wrMask  = bus.we & (bus.memAddr == MASK_ADDR);
    assign wrEoi   = bus.we & (bus.memAddr == EOI_ADDR);
    assign rdPend  = bus.re & ~bus.we & (bus.memAddr == PEND_ADDR);
    assign rdMask  = bus.re & ~bus.we & (bus.memAddr == MASK_ADDR);
    assign rdCause = bus.re & ~bus.we & (bus.memAddr == CAUSE_ADDR);

    assign rise     = bus.irqIn & ~irqPrev;
    assign eligible = pend & mask;

    // Descending scan so the lowest eligible index is the last one written.
    always_comb begin
        sel = '0;
        for (int unsigned i = N_DEV; i > 0; i--) begin
            if (eligible[i-1]) sel = 4'(i - 1);
        end
    end

    assign selOneHot   = N_DEV'(1) << selId;
    assign selEligible = |(eligible & selOneHot);
    assign ackNow      = (state == REQ) & selEligible & bus.intAck;
    assign ackClr      = ackNow ? selOneHot : '0;

    assign bus.intReq = (state == REQ);

    always_comb begin
        bus.dataBusOut = '0;
        if (rdPend)  bus.dataBusOut = BITS'(pend);
        if (rdMask)  bus.dataBusOut = BITS'(mask);
        if (rdCause) bus.dataBusOut = BITS'({causeActive, 4'b0000, causeId});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pend        <= '0;
            mask        <= '0;
            irqPrev     <= '0;
            selId       <= '0;
            causeId     <= '0;
            causeActive <= 1'b0;
        end else begin
            irqPrev <= bus.irqIn;
            // A fresh edge on the source being acknowledged survives the clear.
            pend    <= (pend & ~ackClr) | rise;
            if (wrMask) mask <= bus.dataBusIn[N_DEV-1:0];

            case (state)
                IDLE: begin
                    if (|eligible) begin
                        selId <= sel;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (!selEligible) begin
                        state <= IDLE;
                    end else if (bus.intAck) begin
                        causeActive <= 1'b1;
                        causeId     <= selId;
                        state       <= SERV;
                    end
                end
                SERV: begin
                    if (wrEoi) begin
                        causeActive <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
